// File: rtl/vedic_mult_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier. It feeds one 8-bit digit pair per cycle
// through a single combinational vedic 8x8 core and accumulates the shifted partial products.

module vedic2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic t1, t2, c1, hh;
    always_comb begin
        t1   = a[1] & b[0];
        t2   = a[0] & b[1];
        c1   = t1 & t2;
        hh   = a[1] & b[1];
        p[0] = a[0] & b[0];
        p[1] = t1 ^ t2;
        p[2] = hh ^ c1;
        p[3] = hh & c1;
    end
endmodule

module vedic4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] ll, lh, hl, hh;
    vedic2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(ll));
    vedic2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(lh));
    vedic2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(hl));
    vedic2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(hh));
    assign p = 8'(ll) + (8'(lh) << 2) + (8'(hl) << 2) + (8'(hh) << 4);
endmodule

module vedic8x8ppa (
    input  logic [7:0]  ain,
    input  logic [7:0]  bin,
    output logic [15:0] s_sum,
    output logic        c_cout
);
    logic [7:0]  ll, lh, hl, hh;
    logic [16:0] tot;
    vedic4x4 u_ll (.a(ain[3:0]), .b(bin[3:0]), .p(ll));
    vedic4x4 u_lh (.a(ain[3:0]), .b(bin[7:4]), .p(lh));
    vedic4x4 u_hl (.a(ain[7:4]), .b(bin[3:0]), .p(hl));
    vedic4x4 u_hh (.a(ain[7:4]), .b(bin[7:4]), .p(hh));
    assign tot    = 17'(ll) + (17'(lh) << 4) + (17'(hl) << 4) + (17'(hh) << 8);
    assign s_sum  = tot[15:0];
    assign c_cout = tot[16];
endmodule

module vedic_mult_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int K  = WIDTH / 8;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_check
        $error("vedic_mult_seq_ctrl: WIDTH must be a multiple of 8 and >= 8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [IW-1:0]      i, j;
    logic               fin;
    logic [7:0]         dig_a, dig_b;
    logic [15:0]        s_sum;
    logic               core_cout_unused;

    assign dig_a = a_reg[8*int'(i) +: 8];
    assign dig_b = b_reg[8*int'(j) +: 8];

    vedic8x8ppa u_core (
        .ain   (dig_a),
        .bin   (dig_b),
        .s_sum (s_sum),
        .c_cout(core_cout_unused)
    );

    // Truncation to 2*WIDTH is exact: the full product always fits.
    assign acc_next = acc + ((2*WIDTH)'(s_sum) << (8 * (int'(i) + int'(j))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            product   <= '0;
            i         <= '0;
            j         <= '0;
            fin       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg    <= a_in;
                    b_reg    <= b_in;
                    acc      <= '0;
                    i        <= '0;
                    j        <= '0;
                    fin      <= 1'b0;
                    state    <= RUN;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                RUN: begin
                    // The last accumulate and the product commit sit on separate edges,
                    // so DONE never waits behind the core + adder path.
                    if (fin) begin
                        product   <= acc;
                        fin       <= 1'b0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        acc <= acc_next;
                        if (j == LAST) begin
                            j <= '0;
                            if (i == LAST) fin <= 1'b1;
                            else           i   <= i + IW'(1);
                        end else begin
                            j <= j + IW'(1);
                        end
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
